// File: rtl/vesa_timing_checker.sv
// vesa_timing_checker
// Monitors a live hsync/vsync/de stream. It measures the line and frame
// geometry, compares every complete frame against the expected mode, and
// reports lock, sticky mismatch flags and the last measured geometry.
//
// Ports
//   clk            pixel clock (only clock)
//   rst            synchronous active-high reset
//   hsync/vsync/de timing stream under test
//   clr_err        clears err_flags (a same-cycle new error still sets)
//   meas_h_*       last latched horizontal measurements (total/active/sync)
//   meas_v_*       last latched vertical measurements (total/active/sync)
//   meas_valid     one-cycle pulse when a complete frame's measurements latch
//   locked         stream matched expectations for LOCK_FRAMES frames
//   err_flags      sticky: [0] h_total [1] h_active [2] h_sync [3] v_total
//                  [4] v_active [5] v_sync [6] timeout
//   frame_cnt      complete frames measured (wraps)
module vesa_timing_checker #(
  parameter int EXP_H_TOTAL  = 2080,
  parameter int EXP_H_ACTIVE = 1920,
  parameter int EXP_H_SYNC   = 32,
  parameter int EXP_V_TOTAL  = 1111,
  parameter int EXP_V_ACTIVE = 1080,
  parameter int EXP_V_SYNC   = 5,
  parameter int HSYNC_POL    = 1,
  parameter int VSYNC_POL    = 0,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        de,
  input  logic        clr_err,
  output logic [15:0] meas_h_total,
  output logic [15:0] meas_h_active,
  output logic [15:0] meas_h_sync,
  output logic [15:0] meas_v_total,
  output logic [15:0] meas_v_active,
  output logic [15:0] meas_v_sync,
  output logic        meas_valid,
  output logic        locked,
  output logic [6:0]  err_flags,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] EH_TOT = 16'(EXP_H_TOTAL);
  localparam logic [15:0] EH_ACT = 16'(EXP_H_ACTIVE);
  localparam logic [15:0] EH_SYN = 16'(EXP_H_SYNC);
  localparam logic [15:0] EV_TOT = 16'(EXP_V_TOTAL);
  localparam logic [15:0] EV_ACT = 16'(EXP_V_ACTIVE);
  localparam logic [15:0] EV_SYN = 16'(EXP_V_SYNC);
  localparam logic [15:0] H_TO   = 16'(2 * EXP_H_TOTAL);
  localparam logic [15:0] V_TO   = 16'(2 * EXP_V_TOTAL);
  localparam logic        HS_POL = 1'(HSYNC_POL);
  localparam logic        VS_POL = 1'(VSYNC_POL);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {S_SEARCH, S_ACQUIRE, S_LOCKED} state_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic en);
    return (en && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  state_t      state_q, state_d;
  logic        hs_a_q, hs_a_q2, vs_a_q, vs_a_q2, de_q;
  logic [15:0] h_cnt_q, hs_cnt_q, de_cnt_q;
  logic [15:0] lines_q, sync_lines_q, act_lines_q;
  logic [2:0]  pend_q;
  logic [3:0]  good_q, good_d, good_inc;
  logic [6:0]  err_q, err_d, err_set;
  logic        meas_valid_q, meas_valid_d;
  logic [15:0] frame_cnt_q;
  logic [15:0] m_htot_q, m_hact_q, m_hsyn_q, m_vtot_q, m_vact_q, m_vsyn_q;
  logic        hs_rise, vs_rise, timeout, de_seen;
  logic [2:0]  h_mis, h_mis_now, v_mis;
  logic [5:0]  pend;

  assign hs_rise  = hs_a_q & ~hs_a_q2;
  assign vs_rise  = vs_a_q & ~vs_a_q2;
  assign timeout  = (h_cnt_q >= H_TO) || (lines_q >= V_TO);
  assign de_seen  = (de_cnt_q != 16'd0);
  assign good_inc = good_q + 4'd1;

  // Blanking lines (no de) are not compared against the active width.
  assign h_mis     = {hs_cnt_q != EH_SYN, de_seen && (de_cnt_q != EH_ACT), h_cnt_q != EH_TOT};
  assign h_mis_now = hs_rise ? h_mis : 3'd0;
  assign v_mis     = {sync_lines_q != EV_SYN, act_lines_q != EV_ACT, lines_q != EV_TOT};
  // The line closed by a coincident hs edge is judged with the frame it ended.
  assign pend      = {v_mis, pend_q | h_mis_now};

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_SEARCH;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_SEARCH;
    end else if (vs_rise) begin
      case (state_q)
        S_SEARCH:  state_d = S_ACQUIRE;
        S_ACQUIRE: if (pend == 6'd0 && good_inc == LOCK_N) state_d = S_LOCKED;
        S_LOCKED:  if (pend != 6'd0) state_d = S_ACQUIRE;
        default:   state_d = S_SEARCH;
      endcase
    end
  end

  // output / datapath control
  always_comb begin
    meas_valid_d = vs_rise && !timeout && (state_q != S_SEARCH);
    good_d       = good_q;
    err_set      = 7'd0;
    if (timeout) begin
      good_d     = 4'd0;
      err_set[6] = 1'b1;
    end else if (vs_rise) begin
      if (state_q == S_SEARCH || pend != 6'd0) good_d = 4'd0;
      else if (state_q == S_ACQUIRE)          good_d = good_inc;
      if (state_q != S_SEARCH) err_set[5:0] = pend;
    end
    err_d = (clr_err ? 7'd0 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hs_a_q <= 1'b0; hs_a_q2 <= 1'b0; vs_a_q <= 1'b0; vs_a_q2 <= 1'b0; de_q <= 1'b0;
      h_cnt_q <= '0; hs_cnt_q <= '0; de_cnt_q <= '0;
      lines_q <= '0; sync_lines_q <= '0; act_lines_q <= '0; pend_q <= '0;
      good_q <= '0; err_q <= '0; meas_valid_q <= 1'b0; frame_cnt_q <= '0;
      m_htot_q <= '0; m_hact_q <= '0; m_hsyn_q <= '0;
      m_vtot_q <= '0; m_vact_q <= '0; m_vsyn_q <= '0;
    end else begin
      hs_a_q  <= (hsync == HS_POL);
      vs_a_q  <= (vsync == VS_POL);
      de_q    <= de;
      hs_a_q2 <= hs_a_q;
      vs_a_q2 <= vs_a_q;
      good_q       <= good_d;
      err_q        <= err_d;
      meas_valid_q <= meas_valid_d;
      if (meas_valid_d) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        m_vtot_q    <= lines_q;
        m_vact_q    <= act_lines_q;
        m_vsyn_q    <= sync_lines_q;
      end
      if (timeout) begin
        h_cnt_q <= '0; hs_cnt_q <= '0; de_cnt_q <= '0;
        lines_q <= '0; sync_lines_q <= '0; act_lines_q <= '0; pend_q <= '0;
      end else begin
        if (hs_rise) begin
          h_cnt_q  <= 16'd1;
          hs_cnt_q <= 16'd1;
          de_cnt_q <= {15'd0, de_q};
          m_htot_q <= h_cnt_q;
          m_hsyn_q <= hs_cnt_q;
          if (de_seen) m_hact_q <= de_cnt_q;
        end else begin
          h_cnt_q  <= sat_inc(h_cnt_q, 1'b1);
          hs_cnt_q <= sat_inc(hs_cnt_q, hs_a_q);
          de_cnt_q <= sat_inc(de_cnt_q, de_q);
        end
        // A coincident hs edge is line 1 of the new frame.
        if (vs_rise) begin
          lines_q      <= {15'd0, hs_rise};
          sync_lines_q <= {15'd0, hs_rise};
          act_lines_q  <= {15'd0, hs_rise && de_seen};
          pend_q       <= 3'd0;
        end else if (hs_rise) begin
          lines_q      <= sat_inc(lines_q, 1'b1);
          sync_lines_q <= sat_inc(sync_lines_q, vs_a_q);
          act_lines_q  <= sat_inc(act_lines_q, de_seen);
          pend_q       <= pend_q | h_mis;
        end
      end
    end
  end

  assign meas_h_total  = m_htot_q;
  assign meas_h_active = m_hact_q;
  assign meas_h_sync   = m_hsyn_q;
  assign meas_v_total  = m_vtot_q;
  assign meas_v_active = m_vact_q;
  assign meas_v_sync   = m_vsyn_q;
  assign meas_valid    = meas_valid_q;
  assign locked        = (state_q == S_LOCKED);
  assign err_flags     = err_q;
  assign frame_cnt     = frame_cnt_q;

endmodule
